alu_2bit: RTL and testbench

//   Small registered arithmetic/logic unit. Computes one of five operations
//   (add, subtract, AND, OR, XOR) on two WIDTH-bit operands, chosen by a 3-bit

---
 rtl/alu_2bit_if.sv | 24 ++
 rtl/alu_2bit.sv | 50 +++++
 tb/tb_alu_2bit.sv | 97 +++++++++
 3 files changed

// File: rtl/alu_2bit_if.sv
// Operand/select/result bundle for the registered ALU.
// The master drives operands and select; the slave returns the registered result.
interface alu_2bit_if #(
   parameter int unsigned WIDTH = 2
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       sel;
   logic [WIDTH:0]   Y;

   modport master (
      output A,
      output B,
      output sel,
      input  Y
   );

   modport slave (
      input  A,
      input  B,
      input  sel,
      output Y
   );
endinterface

// File: rtl/alu_2bit.sv
// Registered ALU: add/sub/and/or/xor on zero-extended operands, one-cycle latency.
// Reserved select codes load zero; synchronous active-low reset clears the result.
module alu_2bit #(
   parameter int unsigned WIDTH = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   alu_2bit_if.slave  bus
);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100
   } op_e;

   logic [WIDTH:0] ax;
   logic [WIDTH:0] bx;
   logic [WIDTH:0] y_d;
   logic [WIDTH:0] y_q;

   assign ax = {1'b0, bus.A};
   assign bx = {1'b0, bus.B};

   // Subtraction wraps modulo 2^(WIDTH+1), so A<B yields the two's complement.
   always_comb begin
      y_d = '0;
      case (bus.sel)
         OP_ADD:  y_d = ax + bx;
         OP_SUB:  y_d = ax - bx;
         OP_AND:  y_d = ax & bx;
         OP_OR:   y_d = ax | bx;
         OP_XOR:  y_d = ax ^ bx;
         default: y_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_q <= '0;
      end else begin
         y_q <= y_d;
      end
   end

   assign bus.Y = y_q;

endmodule

// File: tb/tb_alu_2bit.sv
// Directed-vector bench for alu_2bit with hand-computed expected results.
module tb_alu_2bit;

   localparam int unsigned WIDTH = 2;

   logic clk;
   logic rst_n;
   int unsigned n_checks;
   int unsigned n_errors;
   logic [WIDTH:0] prev_exp;

   alu_2bit_if #(.WIDTH(WIDTH)) bus ();

   alu_2bit #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: Y=%b expected %b", tag, got, exp);
      end
   endtask

   // Drive one vector, confirm Y still holds the previous result, then check after the edge.
   task automatic apply(input string tag, input logic [1:0] a, input logic [1:0] b,
                        input logic [2:0] s, input logic r, input logic [WIDTH:0] exp);
      bus.A   = a;
      bus.B   = b;
      bus.sel = s;
      rst_n   = r;
      #1;
      check_val({tag, "_hold"}, bus.Y, prev_exp);
      @(posedge clk);
      #1;
      check_val(tag, bus.Y, exp);
      prev_exp = exp;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      bus.A    = 2'b11;
      bus.B    = 2'b11;
      bus.sel  = 3'b000;

      @(posedge clk);
      #1;
      check_val("rst_edge1", bus.Y, 3'b000);
      @(posedge clk);
      #1;
      check_val("rst_edge2", bus.Y, 3'b000);
      prev_exp = 3'b000;

      apply("rst_release", 2'b11, 2'b11, 3'b000, 1'b1, 3'b110);

      apply("add_01_10",   2'b01, 2'b10, 3'b000, 1'b1, 3'b011);
      apply("add_max",     2'b11, 2'b11, 3'b000, 1'b1, 3'b110);
      apply("sub_11_01",   2'b11, 2'b01, 3'b001, 1'b1, 3'b010);
      apply("sub_wrap",    2'b00, 2'b01, 3'b001, 1'b1, 3'b111);
      apply("sub_00_11",   2'b00, 2'b11, 3'b001, 1'b1, 3'b101);
      apply("sub_equal",   2'b10, 2'b10, 3'b001, 1'b1, 3'b000);
      apply("and_10_01",   2'b10, 2'b01, 3'b010, 1'b1, 3'b000);
      apply("or_10_01",    2'b10, 2'b01, 3'b011, 1'b1, 3'b011);
      apply("xor_11_10",   2'b11, 2'b10, 3'b100, 1'b1, 3'b001);
      apply("rsv_111",     2'b11, 2'b10, 3'b111, 1'b1, 3'b000);
      apply("or_11_10",    2'b11, 2'b10, 3'b011, 1'b1, 3'b011);
      apply("rsv_101",     2'b11, 2'b10, 3'b101, 1'b1, 3'b000);
      apply("and_11_10",   2'b11, 2'b10, 3'b010, 1'b1, 3'b010);
      apply("rsv_110",     2'b11, 2'b10, 3'b110, 1'b1, 3'b000);

      apply("ms_add",      2'b10, 2'b11, 3'b000, 1'b1, 3'b101);
      apply("ms_or",       2'b01, 2'b11, 3'b011, 1'b1, 3'b011);
      apply("ms_reset",    2'b11, 2'b01, 3'b100, 1'b0, 3'b000);
      apply("ms_xor",      2'b11, 2'b01, 3'b100, 1'b1, 3'b010);
      apply("ms_sub",      2'b11, 2'b00, 3'b001, 1'b1, 3'b011);
      apply("ms_and",      2'b01, 2'b01, 3'b010, 1'b1, 3'b001);
      apply("ms_add2",     2'b01, 2'b01, 3'b000, 1'b1, 3'b010);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
